// File: rtl/ot_binarize.sv
// ot_binarize: buffers one frame of filtered pixels, derives the frame-mean
// threshold floor(sum/NPIX) with a restoring divider, then replays the frame
// as a 1-bit binarized stream with the threshold alongside.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   pixel_in qualifies this cycle (accepted in IDLE/COLLECT only)
//   pixel_in   in   PW-bit filtered pixel
//   out_valid  out  bin_out/thresh_out valid, NPIX consecutive cycles per frame
//   bin_out    out  1 when buffered pixel >= threshold
//   thresh_out out  frame threshold, constant across the output burst
module ot_binarize #(
    parameter int NPIX = 75,
    parameter int PW   = 12,
    parameter int SUMW = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [PW-1:0] pixel_in,
    output logic          out_valid,
    output logic          bin_out,
    output logic [PW-1:0] thresh_out
);
    localparam int CW = $clog2(NPIX + 1);
    localparam int RW = $clog2(NPIX) + 1;
    localparam int DW = $clog2(SUMW + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DIV     = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [SUMW-1:0] sum;
    logic [RW-1:0]   rem;
    logic [DW-1:0]   dcnt;
    logic [PW-1:0]   thr;
    logic [PW-1:0]   buf_mem [NPIX];
    logic [RW:0]     trial;
    logic            ge;

    // sum doubles as the divider's shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom, so after SUMW steps it
    // holds the quotient.
    always_comb begin
        trial = {rem, sum[SUMW-1]};
        ge    = trial >= (RW+1)'(NPIX);
    end

    always_ff @(posedge clk) begin
        if (in_valid && (state == S_IDLE || state == S_COLLECT))
            buf_mem[state == S_IDLE ? CW'(0) : cnt] <= pixel_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sum        <= '0;
            rem        <= '0;
            dcnt       <= '0;
            thr        <= '0;
            out_valid  <= 1'b0;
            bin_out    <= 1'b0;
            thresh_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sum   <= SUMW'(pixel_in);
                        cnt   <= CW'(1);
                        rem   <= '0;
                        dcnt  <= '0;
                        state <= (NPIX == 1) ? S_DIV : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        sum <= sum + SUMW'(pixel_in);
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NPIX - 1))
                            state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem  <= ge ? RW'(trial - (RW+1)'(NPIX)) : RW'(trial);
                    sum  <= {sum[SUMW-2:0], ge};
                    dcnt <= dcnt + DW'(1);
                    if (dcnt == DW'(SUMW - 1)) begin
                        thr   <= {sum[PW-2:0], ge};
                        cnt   <= '0;
                        state <= S_OUT;
                    end
                end
                default: begin
                    if (cnt == CW'(NPIX)) begin
                        out_valid  <= 1'b0;
                        bin_out    <= 1'b0;
                        thresh_out <= '0;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end else begin
                        out_valid  <= 1'b1;
                        bin_out    <= buf_mem[cnt] >= thr;
                        thresh_out <= thr;
                        cnt        <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ot_binarize.sv
// tb_ot_binarize: randomized scoreboard bench for ot_binarize.
module tb_ot_binarize;
    localparam int NPIX = 75;
    localparam int PW   = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          out_valid;
    logic          bin_out;
    logic [PW-1:0] thresh_out;

    typedef struct {
        bit b;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   pix[NPIX];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_first = -1;
    bit   junk_en = 1'b0;
    bit   prev_ov = 1'b0;

    ot_binarize dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pixel_in(pixel_in),
        .out_valid(out_valid), .bin_out(bin_out), .thresh_out(thresh_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (!prev_ov) chk("latency", cyc, exp_first);
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("bin", int'(bin_out), int'(e.b));
                    chk("thresh", int'(thresh_out), e.t);
                end
            end else
                chk("idle_zero", int'({bin_out, thresh_out}), 0);
            prev_ov = out_valid;
        end else
            prev_ov = 1'b0;
    end

    // Reference: threshold is the integer mean of the frame; each pixel is
    // compared against it in input order.
    task automatic drive_frame(input int gap_a, input int gap_b, input int gap_pct, input bit expect_out);
        int s = 0;
        int thr;
        for (int k = 0; k < NPIX; k++) s += pix[k];
        thr = s / NPIX;
        if (expect_out)
            for (int k = 0; k < NPIX; k++) sb.push_back('{pix[k] >= thr, thr});
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pixel_in = PW'(pix[k]);
            if (k == NPIX - 1) exp_first = cyc + 21;
            if (k == gap_a || k == gap_b)
                repeat (3) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    pixel_in = PW'($urandom);
                end
            else if (k != NPIX - 1 && int'($urandom_range(99)) < gap_pct)
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    pixel_in = PW'($urandom);
                end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            in_valid = junk_en && out_valid;
            pixel_in = PW'($urandom);
        end
        in_valid = 1'b0;
        chk("drained", sb.size(), 0);
    endtask

    task automatic run(input int gap_a, input int gap_b, input int gap_pct);
        drive_frame(gap_a, gap_b, gap_pct, 1'b1);
        wait_done();
    endtask

    task automatic idle_window();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_outs", int'({bin_out, thresh_out}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < NPIX; k++) pix[k] = 100;
        run(-1, -1, 0);
        for (int k = 0; k < NPIX; k++) pix[k] = 50 * k;
        run(-1, -1, 0);
        for (int k = 0; k < NPIX; k++) pix[k] = 4095;
        run(-1, -1, 0);
        for (int k = 0; k < NPIX; k++) pix[k] = (k == 40) ? 4095 : 0;
        run(-1, -1, 0);
        for (int k = 0; k < NPIX; k++) pix[k] = 0;
        run(-1, -1, 0);
        for (int k = 0; k < NPIX; k++) pix[k] = 50 * k;
        run(10, 60, 0);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(4095));
            junk_en = f[0];
            run(-1, -1, 20);
        end
        junk_en = 1'b0;

        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(4095));
        drive_frame(-1, -1, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_div_valid", int'(out_valid), 0);
        chk("rst_div_outs", int'({bin_out, thresh_out}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_window();

        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(4095));
        drive_frame(-1, -1, 0, 1'b1);
        for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
        chk("burst_started", int'(out_valid), 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_outs", int'({bin_out, thresh_out}), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_window();

        junk_en = 1'b1;
        for (int k = 0; k < NPIX; k++) pix[k] = 100;
        run(-1, -1, 0);
        junk_en = 1'b0;
        for (int k = 0; k < NPIX; k++) pix[k] = 50 * k;
        run(-1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1);
    end
endmodule
